rv32i_wb_unit: RTL
==================

// Module: rv32i_wb_unit
// PURPOSE
// Writeback unit: the producer side of the rv32i register-file write port. It queues completed
// results from execute/load in a DEPTH-entry FIFO and formats load data (byte/half/word,
// sign/zero extend). It drives wb_enable/wb_reg/wb_data into rv32i_reg one result per cycle.
// It also exports a pending-write mask that issue logic uses for RAW hazard checks.
// PARAMETERS
// DEPTH  4   FIFO entries; power of 2, >= 2
// PORTS
// clk          input   1   system clock, all state on posedge
// reset        input   1   asynchronous, active-low (0 = reset asserted)
// in_valid     input   1   result presented by execute/load stage
// in_ready     output  1   unit can accept a result this cycle
// in_rd        input   5   destination register
// in_is_load   input   1   1 = in_data is raw memory word needing formatting
// in_funct3    input   3   load type (LB/LH/LW/LBU/LHU encoding), ignored if !in_is_load
// in_addr_lo   input   2   load address bits [1:0]
// in_data      input   32  ALU result or raw aligned memory word
// wb_hold      input   1   1 = do not retire this cycle (regfile port stalled)
// wb_enable    output  1   to rv32i_reg.wb_enable
// wb_reg       output  5   to rv32i_reg.wb_reg
// wb_data      output  32  to rv32i_reg.wb_data
// busy_mask    output  32  bit r = write to xr pending (in FIFO or on wb_* this cycle)
// count        output  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
// - Reset (reset=0, async): FIFO emptied, count=0, wb_enable=0, wb_reg=0, wb_data=0, busy_mask=0.
//   Reset mid-operation discards all queued results; no write is emitted for them.
// - in_ready = (count != DEPTH); purely state-based, no dependence on in_valid or wb_hold.
// - Push on posedge when in_valid && in_ready. Store rd and formatted data (formatting at push).
// - Pop on posedge when count != 0 && !wb_hold. Popped entry loads the wb_* registers.
//   wb_enable <= (popped rd != 0). If no pop: wb_enable <= 0, wb_reg/wb_data hold last value.
// - Push and pop in the same cycle: count unchanged. Full FIFO never pushes (in_ready=0).
// - Latency: result accepted at edge N -> earliest wb_enable=1 in cycle after edge N+1.
//   FIFO order is preserved; one retire per cycle max.
// - rd=0: entry accepted and popped normally, but wb_enable stays 0 and busy bit 0 is never set.
// - Load formatting (in_is_load=1), b = byte at in_addr_lo, h = half at in_addr_lo[1]:
//   000 LB  {{24{b[7]}},b} | 001 LH {{16{h[15]}},h} | 010 LW in_data
//   100 LBU {24'b0,b}      | 101 LHU {16'b0,h}       | 011/110/111: in_data unchanged
//   LH/LHU ignore in_addr_lo[0] (no misalignment trap here).
// - in_is_load=0: data stored unchanged.
// - busy_mask (combinational from state):
//   OR of onehot(rd) over valid FIFO entries, OR onehot(wb_reg) when wb_enable=1; bit 0 always 0.
//   Registers being written this cycle stay busy: regfile updates at the end of the cycle.
// - Pointers wrap modulo DEPTH. count is exact at full (DEPTH) and empty (0).
// TESTING
// 1 Reset: drive reset=0 mid-stream with 3 entries queued
//   -> next cycle count=0, wb_enable=0, busy_mask=0, in_ready=1; queued writes never appear.
// 2 Single ALU result: rd=5, data=32'hDEADBEEF at edge N
//   -> wb_enable=1, wb_reg=5, wb_data=DEADBEEF in cycle after N+1; busy_mask[5]=1 from N until that cycle ends.
// 3 Loads with in_data=32'h80FF7F01:
//   LB addr 3 -> FFFFFF80; LBU addr 3 -> 00000080; LH addr 2 -> FFFF80FF;
//   LHU addr 0 -> 00007F01; LB addr 1 -> 0000007F.
// 4 Fill: wb_hold=1, push 5 results -> first 4 accepted, in_ready=0, count=4;
//   release hold -> 4 writes in order, one per cycle.
// 5 Simultaneous push and pop at count=2 -> count stays 2, output order intact across pointer wrap.
// 6 rd=0 result, data=1234 -> consumed with wb_enable=0, busy_mask[0]=0; the following rd=7 result retires next cycle.

Source files
------------

// File: rtl/rv32i_wb_unit_if.sv
// Handshake bundle between execute/load, the writeback unit and the regfile port.
// slave: writeback unit side. master: producer/regfile side.
interface rv32i_wb_unit_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rd;
    logic          in_is_load;
    logic [2:0]    in_funct3;
    logic [1:0]    in_addr_lo;
    logic [31:0]   in_data;
    logic          wb_hold;
    logic          wb_enable;
    logic [4:0]    wb_reg;
    logic [31:0]   wb_data;
    logic [31:0]   busy_mask;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_rd, in_is_load, in_funct3,
        input  in_addr_lo, in_data, wb_hold,
        output in_ready, wb_enable, wb_reg, wb_data,
        output busy_mask, count
    );

    modport master (
        output in_valid, in_rd, in_is_load, in_funct3,
        output in_addr_lo, in_data, wb_hold,
        input  in_ready, wb_enable, wb_reg, wb_data,
        input  busy_mask, count
    );
endinterface

// File: rtl/rv32i_wb_unit.sv
// Writeback unit: DEPTH-entry result FIFO with load formatting at push,
// retiring one result per cycle into the regfile write port, plus a pending-write mask.
// Ports: clk, reset (async, active-low), bus (rv32i_wb_unit_if.slave).
module rv32i_wb_unit #(
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    rv32i_wb_unit_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          wb_enable_q;
    logic [4:0]    wb_reg_q;
    logic [31:0]   wb_data_q;

    logic          push, pop;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   fmt_data;
    logic [31:0]   busy_d;
    logic [AW-1:0] idx;

    assign bus.in_ready = (count_q != CW'(DEPTH));
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (count_q != '0) && !bus.wb_hold;

    always_comb begin
        byte_sel = 8'(bus.in_data >> {bus.in_addr_lo, 3'b000});
        half_sel = bus.in_addr_lo[1] ? bus.in_data[31:16] : bus.in_data[15:0];
        fmt_data = bus.in_data;
        if (bus.in_is_load) begin
            case (bus.in_funct3)
                3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
                3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
                3'b100:  fmt_data = {24'b0, byte_sel};
                3'b101:  fmt_data = {16'b0, half_sel};
                default: fmt_data = bus.in_data;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // Entries still queued plus the one on the write port this cycle are busy;
    // the regfile only commits at the end of the cycle.
    always_comb begin
        busy_d = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + AW'(k);
            if (k < int'(count_q))
                busy_d[rd_q[idx]] = 1'b1;
        end
        if (wb_enable_q)
            busy_d[wb_reg_q] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k]   <= '0;
                data_q[k] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wb_enable_q <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            if (push) begin
                rd_q[wr_ptr_q]   <= bus.in_rd;
                data_q[wr_ptr_q] <= fmt_data;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                wb_enable_q <= (rd_q[rd_ptr_q] != 5'd0);
                wb_reg_q    <= rd_q[rd_ptr_q];
                wb_data_q   <= data_q[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + 1'b1;
            end else begin
                wb_enable_q <= 1'b0;
            end
            count_q <= count_d;
        end
    end

    assign bus.wb_enable = wb_enable_q;
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.busy_mask = busy_d;
    assign bus.count     = count_q;
endmodule
